// File: rtl/cache_bus_pkg.sv
// -----------------------------------------------------------------------------
// cache_bus_pkg
// Shared definitions for the CPU-side L1 cache bus. The CPU model, the cache
// core and the bus port all use this package.
//   - bus and field widths
//   - command codes carried on C1, plus the RESPONSE code
//   - bus port FSM state encoding
//   - DETHRONE constants: high-Z values used when the port releases the bus
// -----------------------------------------------------------------------------
package cache_bus_pkg;

    localparam int TAG_W    = 10;
    localparam int SET_W    = 5;
    localparam int OFFSET_W = 4;
    localparam int CMD_W    = 3;
    localparam int BUS_W    = 16;
    localparam int WORD_W   = 32;

    // Commands the CPU places on C1. Code 7 means WRITE32 when the CPU drives it.
    // It means RESPONSE when the port drives it, so the direction tells them apart.
    typedef enum logic [CMD_W-1:0] {
        CMD_NOP             = 3'd0,
        CMD_READ8           = 3'd1,
        CMD_READ16          = 3'd2,
        CMD_READ32          = 3'd3,
        CMD_INVALIDATE_LINE = 3'd4,
        CMD_WRITE8          = 3'd5,
        CMD_WRITE16         = 3'd6,
        CMD_WRITE32         = 3'd7
    } cmd_e;

    localparam logic [CMD_W-1:0] CMD_RESPONSE  = 3'd7;
    localparam logic [CMD_W-1:0] DETHRONE_CMD  = {CMD_W{1'bz}};
    localparam logic [BUS_W-1:0] DETHRONE_DATA = {BUS_W{1'bz}};

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR2     = 3'd1,
        ST_TURN      = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_WAIT_RESP = 3'd4,
        ST_RESP1     = 3'd5,
        ST_RESP2     = 3'd6
    } port_state_e;

    function automatic logic isReadCmd(input logic [CMD_W-1:0] cmd);
        return (cmd == CMD_READ8) || (cmd == CMD_READ16) || (cmd == CMD_READ32);
    endfunction

    function automatic logic isWriteCmd(input logic [CMD_W-1:0] cmd);
        return (cmd == CMD_WRITE8) || (cmd == CMD_WRITE16) || (cmd == CMD_WRITE32);
    endfunction

endpackage

// File: rtl/cache_cpu_port_if.sv
// -----------------------------------------------------------------------------
// cache_cpu_port_if
// Handshake between the CPU bus port and the cache core.
//   master (bus port): drives the req_* payload and req_valid.
//                      Receives req_ready, resp_valid and resp_rdata.
//   slave  (cache core): the mirror image of master.
// The payload holds steady while req_valid is high. The request transfers on
// a clock edge where req_valid and req_ready are both high. resp_valid is a
// single-cycle pulse, and resp_rdata is sampled in that same cycle.
// -----------------------------------------------------------------------------
interface cache_cpu_port_if #(
    parameter int TAG_W    = cache_bus_pkg::TAG_W,
    parameter int SET_W    = cache_bus_pkg::SET_W,
    parameter int OFFSET_W = cache_bus_pkg::OFFSET_W
);

    logic                              req_valid;
    logic                              req_ready;
    logic [cache_bus_pkg::CMD_W-1:0]   req_cmd;
    logic [TAG_W-1:0]                  req_tag;
    logic [SET_W-1:0]                  req_set;
    logic [OFFSET_W-1:0]               req_offset;
    logic [cache_bus_pkg::WORD_W-1:0]  req_wdata;
    logic                              resp_valid;
    logic [cache_bus_pkg::WORD_W-1:0]  resp_rdata;

    modport master (
        output req_valid, req_cmd, req_tag, req_set, req_offset, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_cmd, req_tag, req_set, req_offset, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );

endinterface

// File: rtl/cache_cpu_port.sv
// -----------------------------------------------------------------------------
// cache_cpu_port
// CPU-side bus port of the L1 cache.
// It decodes a request from the shared C1/A1/D1 bus and collects the two-beat
// address and write data. It hands the finished request to the cache core
// over a valid/ready handshake. When the core answers, the port drives
// RESPONSE beats on C1/D1 and then releases the bus.
// Ports:
//   clk    - system clock; all bus sampling and driving is on the rising edge
//   reset  - asynchronous, active-high
//   C1     - command bus (inout); the port drives it only during response beats
//   A1     - address bus from the CPU: {tag,set} in beat 1, offset in beat 2
//   D1     - data bus (inout); the port drives it only during read response beats
//   busy   - high in every state except IDLE
//   core   - request/response handshake to the cache core (master side)
// -----------------------------------------------------------------------------
module cache_cpu_port
    import cache_bus_pkg::*;
#(
    parameter int TAG_W    = cache_bus_pkg::TAG_W,
    parameter int SET_W    = cache_bus_pkg::SET_W,
    parameter int OFFSET_W = cache_bus_pkg::OFFSET_W
) (
    input  logic                   clk,
    input  logic                   reset,
    inout  wire  [CMD_W-1:0]       C1,
    input  logic [TAG_W+SET_W-1:0] A1,
    inout  wire  [BUS_W-1:0]       D1,
    output logic                   busy,
    cache_cpu_port_if.master       core
);

    port_state_e           state_q, state_d;
    logic [CMD_W-1:0]      cmd_q, cmd_d;
    logic [TAG_W-1:0]      tag_q, tag_d;
    logic [SET_W-1:0]      set_q, set_d;
    logic [OFFSET_W-1:0]   offset_q, offset_d;
    logic [WORD_W-1:0]     wdata_q, wdata_d;
    logic [WORD_W-1:0]     rdata_q, rdata_d;

    logic                  reqValid;
    logic                  busyFlag;
    logic                  driveCmd;
    logic                  driveData;
    logic [BUS_W-1:0]      dataOut;

    // State and capture registers.
    // Reset clears every field, so a request in flight to the core is dropped
    // and the bus drivers switch off right away.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cmd_q    <= '0;
            tag_q    <= '0;
            set_q    <= '0;
            offset_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            tag_q    <= tag_d;
            set_q    <= set_d;
            offset_q <= offset_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    // Next-state and capture logic, plus the decoded outputs.
    // C1 is only looked at in IDLE, so the port never holds more than one
    // request at a time.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        tag_d     = tag_q;
        set_d     = set_q;
        offset_d  = offset_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        reqValid  = 1'b0;
        busyFlag  = (state_q != ST_IDLE);
        driveCmd  = 1'b0;
        driveData = 1'b0;
        dataOut   = rdata_q[BUS_W-1:0];

        case (state_q)
            ST_IDLE: begin
                // NOP, or an undriven or unknown C1, falls through to default and is ignored.
                case (C1)
                    CMD_READ8, CMD_READ16, CMD_READ32, CMD_INVALIDATE_LINE,
                    CMD_WRITE8, CMD_WRITE16, CMD_WRITE32: begin
                        cmd_d          = C1;
                        {tag_d, set_d} = A1;
                        // Clear stale data from an earlier write before this capture.
                        wdata_d        = '0;
                        if (isWriteCmd(C1)) begin
                            wdata_d[BUS_W-1:0] = D1;
                        end
                        state_d = ST_ADDR2;
                    end
                    default: ;
                endcase
            end

            ST_ADDR2: begin
                offset_d = A1[OFFSET_W-1:0];
                if ((cmd_q == CMD_WRITE16) || (cmd_q == CMD_WRITE32)) begin
                    wdata_d[WORD_W-1:BUS_W] = D1;
                end
                state_d = ST_TURN;
            end

            // Bus turnaround: the CPU releases C1/D1 and the port drives nothing.
            ST_TURN: begin
                state_d = ST_ISSUE;
            end

            ST_ISSUE: begin
                reqValid = 1'b1;
                if (core.req_ready) begin
                    state_d = ST_WAIT_RESP;
                end
            end

            // Only this state accepts resp_valid. A pulse in the same cycle as
            // the transfer arrives while still in ISSUE, so it is ignored.
            ST_WAIT_RESP: begin
                if (core.resp_valid) begin
                    rdata_d = core.resp_rdata;
                    state_d = ST_RESP1;
                end
            end

            ST_RESP1: begin
                driveCmd  = 1'b1;
                driveData = isReadCmd(cmd_q);
                state_d   = (cmd_q == CMD_READ32) ? ST_RESP2 : ST_IDLE;
            end

            ST_RESP2: begin
                driveCmd  = 1'b1;
                driveData = 1'b1;
                dataOut   = rdata_q[WORD_W-1:BUS_W];
                state_d   = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy            = busyFlag;
    assign core.req_valid  = reqValid;
    assign core.req_cmd    = cmd_q;
    assign core.req_tag    = tag_q;
    assign core.req_set    = set_q;
    assign core.req_offset = offset_q;
    assign core.req_wdata  = wdata_q;

    // Drivers come from registered state only. The bus is released on the same
    // edge that leaves a response state, and no trailing NOP is driven.
    assign C1 = driveCmd  ? CMD_RESPONSE : DETHRONE_CMD;
    assign D1 = driveData ? dataOut      : DETHRONE_DATA;

endmodule

// File: tb/tb_cache_cpu_port.sv
// -----------------------------------------------------------------------------
// tb_cache_cpu_port
// Directed, self-checking bench for cache_cpu_port.
// The bench plays the CPU on C1/A1/D1 and the cache core on the interface.
// Expected response beats go into a queue when a request is driven, and are
// popped as the port drives each RESPONSE beat.
// C1 and D1 are pulled low here, so a released bus reads as zero.
// -----------------------------------------------------------------------------
module tb_cache_cpu_port;
    import cache_bus_pkg::*;

    localparam int ADDR_W = TAG_W + SET_W;

    typedef struct packed {
        logic             driven;
        logic [BUS_W-1:0] data;
        logic             last;
    } beat_t;

    logic               clk;
    logic               reset;
    wire  [CMD_W-1:0]   C1;
    wire  [BUS_W-1:0]   D1;
    logic [ADDR_W-1:0]  A1;
    logic               busy;

    logic               cpuCmdDrive;
    logic [CMD_W-1:0]   cpuCmd;
    logic               cpuDataDrive;
    logic [BUS_W-1:0]   cpuData;

    int                 checks;
    int                 errors;
    int                 waited;
    beat_t              expBeats[$];

    cache_cpu_port_if coreBus ();

    assign C1 = cpuCmdDrive  ? cpuCmd  : {CMD_W{1'bz}};
    assign D1 = cpuDataDrive ? cpuData : {BUS_W{1'bz}};
    pulldown (C1);
    pulldown (D1);

    cache_cpu_port dut (
        .clk   (clk),
        .reset (reset),
        .C1    (C1),
        .A1    (A1),
        .D1    (D1),
        .busy  (busy),
        .core  (coreBus)
    );

    // Free-running clock with a 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stop a hung run before it eats the cycle budget.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no end of test, expected finish before 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [WORD_W-1:0] observed,
                               input logic [WORD_W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // CPU side: beat 1 carries the command and {tag,set}; beat 2 carries the offset.
    // On return the bus is released and the port sits in TURN.
    task automatic applyStimulus(input logic [CMD_W-1:0] cmd, input logic [ADDR_W-1:0] addr,
                                 input logic [OFFSET_W-1:0] offset,
                                 input logic [BUS_W-1:0] beat1, input logic [BUS_W-1:0] beat2);
        cpuCmdDrive  = 1'b1;
        cpuCmd       = cmd;
        A1           = addr;
        cpuDataDrive = (cmd >= 3'd5);
        cpuData      = beat1;
        @(negedge clk);
        cpuCmdDrive  = 1'b0;
        A1           = ADDR_W'(offset);
        cpuData      = beat2;
        @(negedge clk);
        cpuDataDrive = 1'b0;
        A1           = '0;
    endtask

    // Queue the response beats the CPU should see for this command and core data.
    task automatic pushBeats(input logic [CMD_W-1:0] cmd, input logic [WORD_W-1:0] rdata);
        if (cmd == 3'd3) begin
            expBeats.push_back('{driven: 1'b1, data: rdata[15:0],  last: 1'b0});
            expBeats.push_back('{driven: 1'b1, data: rdata[31:16], last: 1'b1});
        end else if ((cmd == 3'd1) || (cmd == 3'd2)) begin
            expBeats.push_back('{driven: 1'b1, data: rdata[15:0], last: 1'b1});
        end else begin
            expBeats.push_back('{driven: 1'b0, data: 16'h0000, last: 1'b1});
        end
    endtask

    task automatic waitReqValid(input string tag, output int cycles);
        cycles = 0;
        while ((coreBus.req_valid !== 1'b1) && (cycles < 20)) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput(tag, 32'(coreBus.req_valid), 32'd1);
    endtask

    task automatic checkRequest(input string tag, input logic [CMD_W-1:0] cmd,
                                input logic [ADDR_W-1:0] addr, input logic [OFFSET_W-1:0] offset);
        checkOutput({tag, "_cmd"},    32'(coreBus.req_cmd), 32'(cmd));
        checkOutput({tag, "_tagset"}, 32'({coreBus.req_tag, coreBus.req_set}), 32'(addr));
        checkOutput({tag, "_offset"}, 32'(coreBus.req_offset), 32'(offset));
    endtask

    // Core side: accept the request, then pulse resp_valid `latency` cycles later.
    task automatic completeRequest(input int latency, input logic [WORD_W-1:0] rdata);
        coreBus.req_ready = 1'b1;
        @(negedge clk);
        coreBus.req_ready = 1'b0;
        checkOutput("reqValidDrops", 32'(coreBus.req_valid), 32'd0);
        repeat (latency - 1) @(negedge clk);
        coreBus.resp_valid = 1'b1;
        coreBus.resp_rdata = rdata;
        @(negedge clk);
        coreBus.resp_valid = 1'b0;
        coreBus.resp_rdata = '0;
    endtask

    task automatic checkBeat(input string tag, output logic last);
        beat_t b;
        last = 1'b1;
        if (expBeats.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s: observed a response beat, expected an empty queue", tag);
        end else begin
            b    = expBeats.pop_front();
            last = b.last;
            checkOutput({tag, "_C1"}, 32'(C1), 32'(CMD_RESPONSE));
            checkOutput({tag, "_D1"}, 32'(D1), b.driven ? 32'(b.data) : 32'd0);
        end
    endtask

    task automatic checkResponse(input string tag);
        logic last;
        int   n;
        n = 0;
        do begin
            checkBeat(tag, last);
            @(negedge clk);
            n++;
        end while (!last && (n < 4));
        checkOutput({tag, "_relC1"},  32'(C1),   32'd0);
        checkOutput({tag, "_relD1"},  32'(D1),   32'd0);
        checkOutput({tag, "_idle"},   32'(busy), 32'd0);
    endtask

    // Directed sequence.
    initial begin
        logic last;
        checks             = 0;
        errors             = 0;
        reset              = 1'b1;
        cpuCmdDrive        = 1'b0;
        cpuCmd             = '0;
        cpuDataDrive       = 1'b0;
        cpuData            = '0;
        A1                 = '0;
        coreBus.req_ready  = 1'b0;
        coreBus.resp_valid = 1'b0;
        coreBus.resp_rdata = '0;

        repeat (2) @(negedge clk);
        checkOutput("rstBusy",     32'(busy), 32'd0);
        checkOutput("rstReqValid", 32'(coreBus.req_valid), 32'd0);
        checkOutput("rstCmd",      32'(coreBus.req_cmd), 32'd0);
        checkOutput("rstTagSet",   32'({coreBus.req_tag, coreBus.req_set}), 32'd0);
        checkOutput("rstOffset",   32'(coreBus.req_offset), 32'd0);
        checkOutput("rstWdata",    coreBus.req_wdata, 32'd0);
        checkOutput("rstC1",       32'(C1), 32'd0);
        checkOutput("rstD1",       32'(D1), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] READ32 with three-cycle core latency");
        pushBeats(CMD_READ32, 32'hDEAD_BEEF);
        applyStimulus(CMD_READ32, ADDR_W'(1337), 4'd8, 16'h0000, 16'h0000);
        checkOutput("turnC1", 32'(C1), 32'd0);
        checkOutput("turnD1", 32'(D1), 32'd0);
        checkOutput("turnBusy", 32'(busy), 32'd1);
        waitReqValid("read32ReqValid", waited);
        checkRequest("read32", CMD_READ32, ADDR_W'(1337), 4'd8);
        completeRequest(3, 32'hDEAD_BEEF);
        checkResponse("read32Resp");

        $display("[TB] WRITE32 with ready tied high and one-cycle core latency");
        pushBeats(CMD_WRITE32, 32'h0);
        applyStimulus(CMD_WRITE32, ADDR_W'(16'h0100), 4'd4, 16'h1234, 16'hABCD);
        waitReqValid("write32ReqValid", waited);
        checkOutput("write32IssueLatency", 32'(waited), 32'd1);
        checkRequest("write32", CMD_WRITE32, ADDR_W'(16'h0100), 4'd4);
        checkOutput("write32Wdata", coreBus.req_wdata, 32'hABCD_1234);
        completeRequest(1, 32'h5555_5555);
        checkResponse("write32Resp");

        $display("[TB] WRITE8 keeps only beat 1 data");
        pushBeats(CMD_WRITE8, 32'h0);
        applyStimulus(CMD_WRITE8, ADDR_W'(16'h7001), 4'd15, 16'h00C3, 16'hFFFF);
        waitReqValid("write8ReqValid", waited);
        checkOutput("write8Wdata", coreBus.req_wdata, 32'h0000_00C3);
        completeRequest(1, 32'h0);
        checkResponse("write8Resp");

        $display("[TB] INVALIDATE_LINE with the core stalling");
        pushBeats(CMD_INVALIDATE_LINE, 32'h0);
        applyStimulus(CMD_INVALIDATE_LINE, ADDR_W'(16'h02A5), 4'd3, 16'h0000, 16'h0000);
        waitReqValid("invReqValid", waited);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("invHold%0d_valid", i), 32'(coreBus.req_valid), 32'd1);
            checkRequest($sformatf("invHold%0d", i), CMD_INVALIDATE_LINE, ADDR_W'(16'h02A5), 4'd3);
            @(negedge clk);
        end
        completeRequest(2, 32'h0);
        checkResponse("invResp");

        $display("[TB] NOP and released C1 are ignored");
        for (int i = 0; i < 10; i++) begin
            cpuCmdDrive  = (i < 5);
            cpuCmd       = 3'd0;
            cpuDataDrive = (i < 5);
            cpuData      = BUS_W'($urandom);
            A1           = ADDR_W'($urandom);
            @(negedge clk);
            checkOutput($sformatf("nop%0d_busy", i),  32'(busy), 32'd0);
            checkOutput($sformatf("nop%0d_valid", i), 32'(coreBus.req_valid), 32'd0);
            if (i >= 5) begin
                checkOutput($sformatf("nop%0d_C1", i), 32'(C1), 32'd0);
                checkOutput($sformatf("nop%0d_D1", i), 32'(D1), 32'd0);
            end
        end
        cpuCmdDrive  = 1'b0;
        cpuDataDrive = 1'b0;
        A1           = '0;

        $display("[TB] spurious resp_valid in IDLE, ISSUE and on the transfer cycle");
        coreBus.resp_valid = 1'b1;
        coreBus.resp_rdata = 32'h1111_2222;
        @(negedge clk);
        coreBus.resp_valid = 1'b0;
        checkOutput("spurIdleC1",   32'(C1), 32'd0);
        checkOutput("spurIdleBusy", 32'(busy), 32'd0);
        pushBeats(CMD_READ16, 32'h0000_9876);
        applyStimulus(CMD_READ16, ADDR_W'(16'h0042), 4'd2, 16'h0000, 16'h0000);
        waitReqValid("spurReqValid", waited);
        coreBus.resp_valid = 1'b1;
        @(negedge clk);
        coreBus.resp_valid = 1'b0;
        checkOutput("spurIssueC1",    32'(C1), 32'd0);
        checkOutput("spurIssueValid", 32'(coreBus.req_valid), 32'd1);
        coreBus.req_ready  = 1'b1;
        coreBus.resp_valid = 1'b1;
        @(negedge clk);
        coreBus.req_ready  = 1'b0;
        coreBus.resp_valid = 1'b0;
        coreBus.resp_rdata = '0;
        checkOutput("spurXferValid", 32'(coreBus.req_valid), 32'd0);
        checkOutput("spurXferC1",    32'(C1), 32'd0);
        checkOutput("spurXferBusy",  32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("spurWaitC1", 32'(C1), 32'd0);
        coreBus.resp_valid = 1'b1;
        coreBus.resp_rdata = 32'h0000_9876;
        @(negedge clk);
        coreBus.resp_valid = 1'b0;
        coreBus.resp_rdata = '0;
        checkResponse("read16Resp");

        $display("[TB] reset during RESP1 of READ32");
        pushBeats(CMD_READ32, 32'hCAFE_F00D);
        applyStimulus(CMD_READ32, ADDR_W'(16'h1234), 4'd6, 16'h0000, 16'h0000);
        waitReqValid("rstReadReqValid", waited);
        completeRequest(1, 32'hCAFE_F00D);
        checkBeat("rstReadBeat1", last);
        reset = 1'b1;
        #1;
        checkOutput("midRstC1",    32'(C1), 32'd0);
        checkOutput("midRstD1",    32'(D1), 32'd0);
        checkOutput("midRstValid", 32'(coreBus.req_valid), 32'd0);
        checkOutput("midRstBusy",  32'(busy), 32'd0);
        checkOutput("midRstCmd",   32'(coreBus.req_cmd), 32'd0);
        checkOutput("midRstTagSet", 32'({coreBus.req_tag, coreBus.req_set}), 32'd0);
        expBeats.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("noResp2C1",   32'(C1), 32'd0);
        checkOutput("noResp2Busy", 32'(busy), 32'd0);

        pushBeats(CMD_READ8, 32'h0000_5A7E);
        applyStimulus(CMD_READ8, ADDR_W'(16'h7FFF), 4'd15, 16'h0000, 16'h0000);
        waitReqValid("read8ReqValid", waited);
        checkRequest("read8", CMD_READ8, ADDR_W'(16'h7FFF), 4'd15);
        completeRequest(1, 32'h0000_5A7E);
        checkResponse("read8Resp");
        checkOutput("queueDrained", 32'(expBeats.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_cpu_port.md
# cache_cpu_port

CPU-side bus port of the L1 cache: decodes requests from the shared C1/A1/D1 bus, reassembles the two-beat address and write data, and hands one complete request at a time to the cache core over a valid/ready handshake. When the core returns a result, the port takes ownership of C1/D1, drives the response beats, then releases the bus to the CPU. It sits directly downstream of the CPU bus master and upstream of the cache core.

## Interface
- TAG_W, 10, tag bits carried in address beat 1
- SET_W, 5, set-index bits carried in address beat 1 (TAG_W+SET_W = A1 width)
- OFFSET_W, 4, byte offset carried in address beat 2 (low bits of A1)
- clk  in  1  system clock; all bus sampling and driving on rising edge
- reset  in  1  asynchronous, active-high
- C1  inout  3  command bus; port drives only while responding, else 3'bzzz
- A1  in  TAG_W+SET_W  address bus from CPU
- D1  inout  16  data bus; port drives only in response beats, else 16'bz
- req_valid  out  1  request to core valid
- req_ready  in  1  core accepts request
- req_cmd  out  3  captured command code
- req_tag / req_set / req_offset  out  TAG_W / SET_W / OFFSET_W  captured address
- req_wdata  out  32  write data, beat 1 in [15:0], beat 2 in [31:16]
- resp_valid  in  1  core result valid (single-cycle pulse)
- resp_rdata  in  32  read data, meaningful only for READ commands
- busy  out  1  high in every state except IDLE

## Operation
- Command codes: NOP 0, READ8 1, READ16 2, READ32 3, INVALIDATE_LINE 4, WRITE8 5, WRITE16 6, WRITE32 7, RESPONSE 7 (direction disambiguates).
- States: IDLE, ADDR2, TURN, ISSUE, WAIT_RESP, RESP1, RESP2.
- IDLE: C1 sampled each edge; 0 or z/x ignored. Commands 1..7 latch cmd, {tag,set}=A1, wdata[15:0]=D1 (writes only) -> ADDR2.
- ADDR2: offset=A1[OFFSET_W-1:0]; WRITE16/WRITE32 latch wdata[31:16]=D1 (WRITE8/16 use beat 1 only; WRITE16 beat 2 data ignored, stored anyway) -> TURN.
- TURN: one idle cycle for CPU to release the bus; port drives nothing -> ISSUE.
- ISSUE: req_valid=1, payload stable; transfer on edge with req_ready=1 -> WAIT_RESP. req_valid drops the cycle after transfer.
- WAIT_RESP: on resp_valid, latch resp_rdata -> RESP1. resp_valid in any other state is ignored.
- RESP1: C1=7, D1=rdata[15:0] for READx, D1 z otherwise. READ32 -> RESP2; others -> IDLE.
- RESP2: C1=7, D1=rdata[31:16] -> IDLE.
- Leaving a response state: C1/D1 released the same edge; no NOP driven.
- Reset (anytime, incl. mid-transfer): state IDLE, req_valid 0, busy 0, C1 and D1 high-Z, latched fields 0; an in-flight core request is abandoned.

## Timing
- Reset values: C1 3'bzzz, D1 16'bz, req_valid 0, req_cmd/tag/set/offset/wdata 0, busy 0.
- Minimum request-to-response latency: command edge to first RESPONSE edge = 4 cycles + core latency (IDLE capture, ADDR2, TURN, ISSUE accept, WAIT_RESP >=1).
- req_ready tied high and resp_valid one cycle after accept: first RESPONSE cycle at edge 5.
- New CPU command accepted only in IDLE; C1 activity in any other state is ignored (single outstanding request).
- resp_valid in the same cycle as the request transfer is not a valid response.

## Structure
- Package cache_bus_pkg: command codes, RESPONSE code, bus widths, state enum, DETHRONE (high-Z) constants; shared with CPU model and cache core.
- No sub-module; one FSM plus capture registers and tri-state drivers.

## Test plan
- READ32 tag/set=1337, offset=8; core returns 0xDEADBEEF after 3 cycles -> req_tag/set form 1337, req_offset 8, then C1=7 two cycles with D1 0xBEEF then 0xDEAD, then bus z.
- WRITE32 addr 0x0100/offset 4, D1 0x1234 then 0xABCD -> req_wdata 0xABCD1234, single RESPONSE cycle, D1 stays z.
- INVALIDATE_LINE with req_ready held low 5 cycles -> req_valid high 5 cycles, payload stable, one RESPONSE after resp_valid.
- C1=NOP and C1=z for 10 cycles -> busy 0, req_valid 0, bus undriven.
- Reset asserted during RESP1 of READ32 -> C1/D1 z immediately, req_valid 0, no RESP2; next READ8 completes normally.
- Spurious resp_valid in IDLE and ISSUE -> ignored; no RESPONSE driven.
